// File: rtl/uart_rx_fifo_if.sv
// Receive-stream handshake between the UART receiver (master) and its host consumer (slave).
// Latency: none, wires only.
// Backpressure: the consumer holds m_ready low to keep the head beat in place.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_BITS-1:0] m_data;
    logic                 m_parity_err;
    logic                 m_frame_err;

    modport master (output m_valid, m_data, m_parity_err, m_frame_err, input m_ready);
    modport slave  (input m_valid, m_data, m_parity_err, m_frame_err, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-FF sync, 3-sample majority vote, runtime parity/stop format, tagged receive FIFO; break detect under UART_RX_BREAK_EN.
// Latency: m_valid rises 1 cycle after the last stop-bit vote (2 more cycles from the pin through the synchronizer).
// Backpressure: m_ready low holds the FIFO; a frame completed while the FIFO is full is dropped and sets sticky overflow.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             serial,
    input  logic                             cfg_parity_en,
    input  logic [1:0]                       cfg_parity_type,
    input  logic                             cfg_two_stop,
    uart_rx_fifo_if.master                   m,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             overflow,
    input  logic                             ovf_clr,
    output logic                             break_det
);
    localparam int CPB   = CLK_FREQ / BAUD_RATE;
    localparam int MID   = CPB / 2;
    localparam int CNT_W = $clog2(CPB);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FCW   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic                 sync1, rx_s;
    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic                 s_a, s_b;
    logic [DATA_BITS-1:0] data_q;
    logic                 par_err_q, frm_err_q;
    logic                 par_en_q, two_stop_q;
    logic [1:0]           par_type_q;
    logic                 vote, par_calc, at_mid1, at_end, frame_last, push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= serial;
            rx_s  <= sync1;
        end
    end

    assign vote       = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
    assign at_mid1    = (cnt == CNT_W'(MID + 1));
    assign at_end     = (cnt == CNT_W'(CPB - 1));
    assign frame_last = (stop_idx == two_stop_q);

    always_comb begin
        par_calc = 1'b0;
        unique case (par_type_q)
            2'd0:    par_calc = vote;
            2'd1:    par_calc = ~vote;
            2'd2:    par_calc = (^data_q) ^ vote;
            default: par_calc = ~((^data_q) ^ vote);
        endcase
    end

`ifdef UART_RX_BREAK_EN
    logic brk_wait, par_bit_q, is_break;
    assign is_break = (state == STOP) && !brk_wait && !stop_idx && at_mid1 && !vote &&
                      (data_q == '0) && !(par_en_q && par_bit_q);
    assign push     = (state == STOP) && !brk_wait && at_mid1 && frame_last && !is_break;
`else
    assign push      = (state == STOP) && at_mid1 && frame_last;
    assign break_det = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            s_a        <= 1'b1;
            s_b        <= 1'b1;
            data_q     <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            par_type_q <= 2'd0;
`ifdef UART_RX_BREAK_EN
            brk_wait   <= 1'b0;
            par_bit_q  <= 1'b0;
            break_det  <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_BREAK_EN
            break_det <= 1'b0;
`endif
            if (state != IDLE) begin
                if (cnt == CNT_W'(MID - 1)) s_a <= rx_s;
                if (cnt == CNT_W'(MID))     s_b <= rx_s;
                cnt <= at_end ? '0 : cnt + 1'b1;
            end
            unique case (state)
                IDLE: if (!rx_s) begin
                    state      <= START;
                    cnt        <= '0;
                    bit_idx    <= '0;
                    stop_idx   <= 1'b0;
                    par_err_q  <= 1'b0;
                    frm_err_q  <= 1'b0;
                    par_en_q   <= cfg_parity_en;
                    par_type_q <= cfg_parity_type;
                    two_stop_q <= cfg_two_stop;
                end
                START: begin
                    if (at_mid1 && vote) state <= IDLE;
                    else if (at_end)     state <= DATA;
                end
                DATA: begin
                    if (at_mid1) data_q <= {vote, data_q[DATA_BITS-1:1]};
                    if (at_end) begin
                        if (bit_idx == BIT_W'(DATA_BITS - 1)) state <= par_en_q ? PARITY : STOP;
                        else                                  bit_idx <= bit_idx + 1'b1;
                    end
                end
                PARITY: begin
                    if (at_mid1) begin
                        par_err_q <= par_calc;
`ifdef UART_RX_BREAK_EN
                        par_bit_q <= vote;
`endif
                    end
                    if (at_end) state <= STOP;
                end
                STOP: begin
`ifdef UART_RX_BREAK_EN
                    // Break: hold here until the line has been high for one full bit time.
                    if (brk_wait) begin
                        if (!rx_s) cnt <= '0;
                        else if (at_end) begin
                            state    <= IDLE;
                            brk_wait <= 1'b0;
                        end
                    end else if (is_break) begin
                        break_det <= 1'b1;
                        brk_wait  <= 1'b1;
                        cnt       <= '0;
                    end else
`endif
                    if (at_mid1) begin
                        // Return to IDLE at mid-stop to regain half a bit of resync margin.
                        if (frame_last) state <= IDLE;
                        else            frm_err_q <= frm_err_q | ~vote;
                    end else if (at_end) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic                 full, do_pop, do_push;

    assign full    = (fifo_count == FCW'(FIFO_DEPTH));
    assign do_pop  = m.m_valid & m.m_ready;
    assign do_push = push & (!full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {data_q, par_err_q, frm_err_q | ~vote};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      fifo_count <= fifo_count + 1'b1;
            else if (!do_push && do_pop) fifo_count <= fifo_count - 1'b1;
            if (push && !do_push) overflow <= 1'b1;
            else if (ovf_clr)     overflow <= 1'b0;
        end
    end

    assign m.m_valid = (fifo_count != '0);
    assign {m.m_data, m.m_parity_err, m.m_frame_err} = mem[rd_ptr];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at CPB=16, 8 data bits, 4-entry FIFO.
module tb_uart_rx_fifo;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial = 1'b1;
    logic       cfg_parity_en = 1'b0;
    logic [1:0] cfg_parity_type = 2'd0;
    logic       cfg_two_stop = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       break_det;

    uart_rx_fifo_if #(.DATA_BITS(8)) ifc ();

    uart_rx_fifo #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .serial(serial),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_type(cfg_parity_type),
        .cfg_two_stop(cfg_two_stop), .m(ifc), .fifo_count(fifo_count),
        .overflow(overflow), .ovf_clr(ovf_clr), .break_det(break_det)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int brk_pulses = 0;
    logic [9:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every accepted beat is compared against the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n && ifc.m_valid && ifc.m_ready) begin
            if (exp_q.size() == 0) chk("unexpected beat", {ifc.m_data, ifc.m_parity_err, ifc.m_frame_err}, 32'hFFFF);
            else chk("beat {data,perr,ferr}", {ifc.m_data, ifc.m_parity_err, ifc.m_frame_err}, exp_q.pop_front());
        end
        if (rst_n && break_det) brk_pulses++;
    end

    task automatic bit_time(input logic v, input logic glitch);
        for (int i = 0; i < CPB; i++) begin
            @(posedge clk);
            #1 serial = (glitch && i == 8) ? ~v : v;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                              input logic two, input logic stop1, input logic stop2, input logic glitch);
        bit_time(1'b0, glitch);
        for (int i = 0; i < 8; i++) bit_time(d[i], glitch);
        if (par_en) bit_time(par_bit, glitch);
        bit_time(stop1, glitch);
        if (two) bit_time(stop2, glitch);
        bit_time(1'b1, 1'b0);
        bit_time(1'b1, 1'b0);
    endtask

    initial begin
        ifc.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset m_valid", ifc.m_valid, 0);
        chk("reset fifo_count", fifo_count, 0);
        chk("reset overflow", overflow, 0);
        chk("reset break_det", break_det, 0);
        chk("reset m_data", ifc.m_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        bit_time(1'b1, 1'b0);

        // 8N1 0xA5 streamed straight through
        exp_q.push_back({8'hA5, 1'b0, 1'b0});
        fork
            send_frame(8'hA5, 0, 0, 0, 1, 1, 0);
            begin
                int k = 0;
                while (!ifc.m_valid && k < 400) begin @(negedge clk); k++; end
                chk("t1 fifo_count at valid", fifo_count, 1);
                @(negedge clk);
                chk("t1 fifo_count after pop", fifo_count, 0);
            end
        join

        // ODD parity on 0x03
        cfg_parity_en = 1'b1; cfg_parity_type = 2'd3;
        exp_q.push_back({8'h03, 1'b1, 1'b0});
        send_frame(8'h03, 1, 0, 0, 1, 1, 0);
        exp_q.push_back({8'h03, 1'b0, 1'b0});
        send_frame(8'h03, 1, 1, 0, 1, 1, 0);
        cfg_parity_en = 1'b0; cfg_parity_type = 2'd0;

        // two stop bits: bad 2nd stop, then single-cycle glitches in every bit
        cfg_two_stop = 1'b1;
        exp_q.push_back({8'h5A, 1'b0, 1'b1});
        send_frame(8'h5A, 0, 0, 1, 1, 0, 0);
        exp_q.push_back({8'hC3, 1'b0, 1'b0});
        send_frame(8'hC3, 0, 0, 1, 1, 1, 1);
        cfg_two_stop = 1'b0;

        // false start: 4-cycle low pulse
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1 serial = 1'b0; end
        @(posedge clk); #1 serial = 1'b1;
        bit_time(1'b1, 1'b0); bit_time(1'b1, 1'b0);
        @(negedge clk);
        chk("t4 fifo_count", fifo_count, 0);
        chk("t4 m_valid", ifc.m_valid, 0);
        chk("t4 overflow", overflow, 0);

        // overflow with consumer stalled
        ifc.m_ready = 1'b0;
        exp_q.push_back({8'h11, 2'b00}); exp_q.push_back({8'h22, 2'b00});
        exp_q.push_back({8'h33, 2'b00}); exp_q.push_back({8'h44, 2'b00});
        send_frame(8'h11, 0, 0, 0, 1, 1, 0);
        send_frame(8'h22, 0, 0, 0, 1, 1, 0);
        send_frame(8'h33, 0, 0, 0, 1, 1, 0);
        send_frame(8'h44, 0, 0, 0, 1, 1, 0);
        send_frame(8'h55, 0, 0, 0, 1, 1, 0);
        @(negedge clk);
        chk("t5 fifo_count full", fifo_count, 4);
        chk("t5 overflow set", overflow, 1);
        chk("t5 head data", ifc.m_data, 8'h11);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        @(negedge clk);
        chk("t5 overflow cleared", overflow, 0);
        ifc.m_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5 fifo drained", fifo_count, 0);

        // reset mid-DATA with a stored frame
        ifc.m_ready = 1'b0;
        send_frame(8'h77, 0, 0, 0, 1, 1, 0);
        @(negedge clk);
        chk("t6 stored frame count", fifo_count, 1);
        bit_time(1'b0, 0); bit_time(1'b1, 0); bit_time(1'b0, 0); bit_time(1'b1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst m_valid", ifc.m_valid, 0);
        chk("t6 rst fifo_count", fifo_count, 0);
        chk("t6 rst m_data", ifc.m_data, 0);
        chk("t6 rst overflow", overflow, 0);
        chk("t6 rst break_det", break_det, 0);
        serial = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        bit_time(1'b1, 0); bit_time(1'b1, 0);
        ifc.m_ready = 1'b1;
        exp_q.push_back({8'h3C, 2'b00});
        send_frame(8'h3C, 0, 0, 0, 1, 1, 0);

`ifdef UART_RX_BREAK_EN
        for (int i = 0; i < 12; i++) bit_time(1'b0, 0);
        for (int i = 0; i < 3; i++) bit_time(1'b1, 0);
        @(negedge clk);
        chk("break pulse count", brk_pulses, 1);
        chk("break not pushed", fifo_count, 0);
`else
        exp_q.push_back({8'h00, 1'b0, 1'b1});
        send_frame(8'h00, 0, 0, 0, 0, 1, 0);
        chk("no break pulses", brk_pulses, 0);
`endif

        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
